// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: DLX ALU opcodes and the arbiter state encoding.
package alu_pkg;

  localparam int unsigned ALU_OP_MAX = 17;

  typedef enum logic [4:0] {
    ALU_LHI    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_ADDU   = 5'd2,
    ALU_SUB    = 5'd3,
    ALU_SUBU   = 5'd4,
    ALU_AND    = 5'd5,
    ALU_OR     = 5'd6,
    ALU_XOR    = 5'd7,
    ALU_SLL    = 5'd8,
    ALU_SRL    = 5'd9,
    ALU_SRA    = 5'd10,
    ALU_SEQ    = 5'd11,
    ALU_SNE    = 5'd12,
    ALU_SLT    = 5'd13,
    ALU_SGT    = 5'd14,
    ALU_SLE    = 5'd15,
    ALU_SGE    = 5'd16,
    ALU_MOVNZ4 = 5'd17
  } alu_op_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle between the ALU clients and the arbiter.
// req_lock exists only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned OPW   = 5
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0][OPW-1:0] req_op;
  logic [N_REQ-1:0][W-1:0]   req_a;
  logic [N_REQ-1:0][W-1:0]   req_b;
`ifdef ALU_ARB_LOCK_EN
  logic [N_REQ-1:0]          req_lock;
`endif
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ-1:0]          rsp_ready;
  logic [W-1:0]              rsp_res;
  logic                      rsp_carry;
  logic                      rsp_z;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
`ifdef ALU_ARB_LOCK_EN
    output req_lock,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_carry, rsp_z, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
`ifdef ALU_ARB_LOCK_EN
    input  req_lock,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_carry, rsp_z, rsp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = (IW+1)'(ptr) + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                 = 1'b1;
        idx                   = cand[IW-1:0];
        grant[cand[IW-1:0]]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered DLX ALU among N_REQ requesters.
// Optional ALU_ARB_LOCK_EN: req_lock holds the pointer on the winner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus,
  output logic           alu_ex,
  output logic [OPW-1:0] alu_i,
  output logic [W-1:0]   alu_op1,
  output logic [W-1:0]   alu_op2,
  input  logic [W-1:0]   alu_res,
  input  logic           alu_carry,
  input  logic           alu_z
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state;
  logic [IW-1:0]    own;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    ptr_inc;
  logic [N_REQ-1:0] grant;
  logic             found;
  logic             issue;
  logic             legal;
  logic             rsp_done;
  logic             err_q;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .found (found)
  );

  // Issue/ALU drive; a new op may issue in the same cycle the previous response is taken.
  always_comb begin
    rsp_done      = (state == ARB_RESP) && bus.rsp_ready[own];
    issue         = rst_n && found && ((state == ARB_IDLE) || rsp_done);
    legal         = bus.req_op[idx] <= OPW'(ALU_OP_MAX);
    ptr_inc       = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
    bus.req_ready = issue ? grant : '0;
    alu_ex        = issue && legal;
    alu_i         = issue ? bus.req_op[idx] : '0;
    alu_op1       = issue ? bus.req_a[idx]  : '0;
    alu_op2       = issue ? bus.req_b[idx]  : '0;
  end

  // Response side depends on state only; the ALU holds its result while alu_ex is low.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_res   = '0;
    bus.rsp_carry = 1'b0;
    bus.rsp_z     = 1'b0;
    bus.rsp_err   = 1'b0;
    if (state == ARB_RESP) begin
      bus.rsp_valid[own] = 1'b1;
      bus.rsp_err        = err_q;
      bus.rsp_res        = err_q ? '0 : alu_res;
      bus.rsp_carry      = !err_q && alu_carry;
      bus.rsp_z          = err_q || alu_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      own   <= '0;
      ptr   <= '0;
      err_q <= 1'b0;
    end else if (issue) begin
      state <= ARB_RESP;
      own   <= idx;
      err_q <= !legal;
`ifdef ALU_ARB_LOCK_EN
      ptr   <= bus.req_lock[idx] ? idx : ptr_inc;
`else
      ptr   <= ptr_inc;
`endif
    end else if (rsp_done) begin
      state <= ARB_IDLE;
      err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU and a reference arbiter model.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 5;

  logic           clk;
  logic           rst_n;
  logic           alu_ex;
  logic [OPW-1:0] alu_i;
  logic [W-1:0]   alu_op1, alu_op2, alu_res;
  logic           alu_carry, alu_z;
  logic [W:0]     alu_nxt;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter_if #(.N_REQ(N), .W(W), .OPW(OPW)) bus ();

  alu_arbiter #(.N_REQ(N), .W(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .alu_ex    (alu_ex),
    .alu_i     (alu_i),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_res   (alu_res),
    .alu_carry (alu_carry),
    .alu_z     (alu_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      5'd0:       alu_fn = {1'b0, b[15:0], 16'h0000};
      5'd1, 5'd2: alu_fn = (W+1)'(a) + (W+1)'(b);
      5'd3, 5'd4: alu_fn = (W+1)'(a) - (W+1)'(b);
      5'd5:       alu_fn = {1'b0, a & b};
      5'd6:       alu_fn = {1'b0, a | b};
      5'd7:       alu_fn = {1'b0, a ^ b};
      default:    alu_fn = {1'b0, a ^ ~b};
    endcase
  endfunction

  // Stand-in for the registered DLX ALU: captures on alu_ex, holds otherwise.
  assign alu_nxt = alu_fn(alu_i, alu_op1, alu_op2);
  always_ff @(posedge clk) begin
    if (alu_ex) begin
      alu_res   <= alu_nxt[W-1:0];
      alu_carry <= alu_nxt[W];
      alu_z     <= (alu_nxt[W-1:0] == '0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state and scoreboard of {err, z, carry, res}
  logic         m_busy;
  int           m_own;
  int           m_ptr;
  logic [W+2:0] sb[$];

  always @(negedge clk) begin
    logic [N-1:0] eg;
    int           g;
    int           c;
    logic         fnd;
    logic         lk;
    logic [W:0]   e;
    logic [W+2:0] ex;
    if (!rst_n) begin
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_carry, bus.rsp_z, bus.rsp_err}), 64'd0);
      check("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
      check("rst_alu", 64'({alu_ex, alu_i, alu_op1}), 64'd0);
      m_busy = 1'b0;
      m_own  = 0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      eg  = '0;
      g   = 0;
      fnd = 1'b0;
      if (!m_busy || bus.rsp_ready[m_own]) begin
        for (int k = 0; k < int'(N); k++) begin
          c = (m_ptr + k) % int'(N);
          if (!fnd && bus.req_valid[c]) begin
            fnd   = 1'b1;
            g     = c;
            eg[c] = 1'b1;
          end
        end
      end
      check("req_ready", 64'(bus.req_ready), 64'(eg));
      check("rsp_valid", 64'(bus.rsp_valid), m_busy ? 64'(1 << m_own) : 64'd0);
      if (m_busy) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          check("rsp_payload", 64'({bus.rsp_err, bus.rsp_z, bus.rsp_carry, bus.rsp_res}), 64'(sb[0]));
        end
      end
      if (fnd) begin
        check("alu_ex", 64'(alu_ex), 64'(bus.req_op[g] <= 5'd17));
        check("alu_ops", {alu_op1, alu_op2}, {bus.req_a[g], bus.req_b[g]});
        check("alu_i", 64'(alu_i), 64'(bus.req_op[g]));
        e  = alu_fn(bus.req_op[g], bus.req_a[g], bus.req_b[g]);
        ex = (bus.req_op[g] > 5'd17) ? {1'b1, 1'b1, 1'b0, {W{1'b0}}}
                                     : {1'b0, (e[W-1:0] == '0), e[W], e[W-1:0]};
      end else begin
        check("alu_idle", 64'({alu_ex, alu_i, alu_op1}), 64'd0);
        ex = '0;
      end
      if (m_busy && bus.rsp_ready[m_own]) begin
        if (sb.size() != 0) void'(sb.pop_front());
        m_busy = 1'b0;
      end
      if (fnd) begin
        sb.push_back(ex);
`ifdef ALU_ARB_LOCK_EN
        lk = bus.req_lock[g];
`else
        lk = 1'b0;
`endif
        m_busy = 1'b1;
        m_own  = g;
        m_ptr  = lk ? g : (g + 1) % int'(N);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
`ifdef ALU_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_op[i]    = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  task automatic do_reset();
    clear_reqs();
    bus.rsp_ready = '1;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready = '1;
    cyc();
    @(negedge clk);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single ADD with carry out and zero result
    set_req(0, 5'(ALU_ADD), 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check("t1_req_ready", 64'(bus.req_ready), 64'h1);
    check("t1_alu_ex", 64'(alu_ex), 64'd1);
    cyc();
    clear_reqs();
    @(negedge clk);
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("t1_rsp", 64'({bus.rsp_res, bus.rsp_carry, bus.rsp_z, bus.rsp_err}), 64'b0110);
    cyc();
    cyc();

    // All four continuously valid: strict rotation, one op per cycle
    do_reset();
    for (int i = 0; i < int'(N); i++) set_req(i, 5'(ALU_ADD), 32'(i * 16), 32'(i + 1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t2_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
      cyc();
    end
    clear_reqs();
    cyc();
    cyc();

    // Back-pressure on requester 1 blocks requester 2 until the accept cycle
    do_reset();
    set_req(1, 5'(ALU_SUB), 32'd5, 32'd3);
    @(negedge clk);
    check("t3_issue", 64'(bus.req_ready), 64'h2);
    cyc();
    clear_reqs();
    set_req(2, 5'(ALU_ADD), 32'd7, 32'd8);
    bus.rsp_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", 64'(bus.rsp_valid), 64'h2);
      check("t3_hold_res", 64'(bus.rsp_res), 64'd2);
      check("t3_blocked", 64'(bus.req_ready), 64'd0);
      cyc();
    end
    bus.rsp_ready = '1;
    @(negedge clk);
    check("t3_accept_issue", 64'(bus.req_ready), 64'h4);
    cyc();
    clear_reqs();
    @(negedge clk);
    check("t3_req2_res", 64'({bus.rsp_valid, bus.rsp_res}), {32'h4, 32'd15});
    cyc();
    cyc();

    // Illegal opcode gets the forced error payload
    do_reset();
    set_req(3, 5'd20, 32'h1234, 32'h5678);
    @(negedge clk);
    check("t4_issue", 64'(bus.req_ready), 64'h8);
    check("t4_alu_ex", 64'(alu_ex), 64'd0);
    cyc();
    clear_reqs();
    @(negedge clk);
    check("t4_rsp", 64'({bus.rsp_valid, bus.rsp_res, bus.rsp_carry, bus.rsp_z, bus.rsp_err}),
          {28'd0, 4'h8, 32'd0, 3'b011});
    cyc();
    cyc();

    // Reset asserted while a response is pending
    do_reset();
    set_req(0, 5'(ALU_OR), 32'hF0, 32'h0F);
    cyc();
    clear_reqs();
    bus.rsp_ready = '0;
    @(negedge clk);
    check("t5_pending", 64'(bus.rsp_valid), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_clear", 64'({bus.rsp_valid, bus.rsp_res, bus.rsp_z, bus.rsp_err}), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.rsp_ready = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_stale", 64'(bus.rsp_valid), 64'd0);
      cyc();
    end

`ifdef ALU_ARB_LOCK_EN
    // Locked winner keeps priority for one extra grant
    do_reset();
    set_req(0, 5'(ALU_SUB), 32'd9, 32'd4);
    set_req(1, 5'(ALU_ADD), 32'd1, 32'd1);
    bus.req_lock[0] = 1'b1;
    @(negedge clk);
    check("t6_lock_g0", 64'(bus.req_ready), 64'h1);
    cyc();
    bus.req_lock[0] = 1'b0;
    bus.req_op[0]   = 5'(ALU_SLT);
    @(negedge clk);
    check("t6_lock_g1", 64'(bus.req_ready), 64'h1);
    cyc();
    @(negedge clk);
    check("t6_after_lock", 64'(bus.req_ready), 64'h2);
    cyc();
    clear_reqs();
    cyc();
    cyc();
`endif

    // Random soak with random back-pressure; the monitor model checks every cycle
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < int'(N); i++) begin
        bus.req_valid[i] = ($urandom_range(0, 2) != 0);
        bus.req_op[i]    = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(18, 31))
                                                      : 5'($urandom_range(0, 17));
        bus.req_a[i]     = $urandom;
        bus.req_b[i]     = ($urandom_range(0, 3) == 0) ? bus.req_a[i] : $urandom;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock[i]  = ($urandom_range(0, 3) == 0);
`endif
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end
    clear_reqs();
    bus.rsp_ready = '1;
    cyc();
    cyc();
    @(negedge clk);
    check("drain_idle", 64'(bus.rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
